// File: rtl/opendap_mem_ap_apb_if.sv
// AP-side (from SW-DP) and APB-side signal bundle for the minimal MEM-AP.
interface opendap_mem_ap_apb_if;
  // AP interface from the SW-DP
  logic [7:0]  ap_sel;
  logic [5:0]  ap_addr;
  logic [31:0] ap_wdata;
  logic        ap_wen;
  logic        ap_ren;
  logic        ap_abort;
  logic [31:0] ap_rdata;
  logic        ap_rdy;
  logic        ap_err;
  // APB3 master port
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  // MEM-AP view: serves the DP, masters the APB
  modport slave (
    input  ap_sel, ap_addr, ap_wdata, ap_wen, ap_ren, ap_abort,
    input  prdata, pready, pslverr,
    output ap_rdata, ap_rdy, ap_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  // Environment view: DP requester plus APB completer
  modport master (
    output ap_sel, ap_addr, ap_wdata, ap_wen, ap_ren, ap_abort,
    output prdata, pready, pslverr,
    input  ap_rdata, ap_rdy, ap_err,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/opendap_mem_ap_apb.sv
// Minimal MEM-AP: CSW/TAR/DRW/BDx/CFG/BASE/IDR, DRW/BDx mapped onto APB3.
module opendap_mem_ap_apb #(
  parameter logic [7:0]  AP_SEL = 8'h00,
  parameter logic [31:0] IDR    = 32'h0477_0002,
  parameter logic [31:0] BASE   = 32'h0000_0003
) (
  input  logic                swclk,
  input  logic                rst_n,
  opendap_mem_ap_apb_if.slave bus
);

  localparam int unsigned DATA_W = 32;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  localparam logic [5:0] A_CSW  = 6'h00;
  localparam logic [5:0] A_TAR  = 6'h01;
  localparam logic [5:0] A_DRW  = 6'h03;
  localparam logic [5:0] A_CFG  = 6'h3D;
  localparam logic [5:0] A_BASE = 6'h3E;
  localparam logic [5:0] A_IDR  = 6'h3F;

  logic [1:0]        r_state,    w_state_nxt;
  logic [DATA_W-1:0] r_tar,      w_tar_nxt;
  logic [1:0]        r_addrinc,  w_addrinc_nxt;
  logic              r_is_drw,   w_is_drw_nxt;
  logic [DATA_W-1:0] r_ap_rdata, w_ap_rdata_nxt;
  logic              r_ap_rdy,   w_ap_rdy_nxt;
  logic              r_ap_err,   w_ap_err_nxt;
  logic              r_psel,     w_psel_nxt;
  logic              r_penable,  w_penable_nxt;
  logic              r_pwrite,   w_pwrite_nxt;
  logic [DATA_W-1:0] r_paddr,    w_paddr_nxt;
  logic [DATA_W-1:0] r_pwdata,   w_pwdata_nxt;

  logic              w_strobe;
  logic              w_sel_hit;
  logic              w_acc;
  logic              w_bus_addr;
  logic [7:0]        w_tar_inc;
  logic [DATA_W-1:0] w_reg_rdata;

  assign w_strobe   = bus.ap_wen | bus.ap_ren;
  assign w_sel_hit  = (bus.ap_sel == AP_SEL);
  assign w_acc      = w_strobe && w_sel_hit && (r_state == S_IDLE);
  assign w_bus_addr = (bus.ap_addr == A_DRW) || (bus.ap_addr[5:2] == 4'b0001);
  assign w_tar_inc  = r_tar[9:2] + 8'd1;

  // Register-file readback mux (non-bus addresses)
  always_comb begin
    w_reg_rdata = '0;
    case (bus.ap_addr)
      A_CSW:   w_reg_rdata = {24'h0, (r_state != S_IDLE), 1'b1, r_addrinc, 1'b0, 3'b010};
      A_TAR:   w_reg_rdata = r_tar;
      A_CFG:   w_reg_rdata = '0;
      A_BASE:  w_reg_rdata = BASE;
      A_IDR:   w_reg_rdata = IDR;
      default: w_reg_rdata = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_tar_nxt      = r_tar;
    w_addrinc_nxt  = r_addrinc;
    w_is_drw_nxt   = r_is_drw;
    w_ap_rdata_nxt = r_ap_rdata;
    w_ap_rdy_nxt   = r_ap_rdy;
    w_ap_err_nxt   = 1'b0;
    w_psel_nxt     = r_psel;
    w_penable_nxt  = r_penable;
    w_pwrite_nxt   = r_pwrite;
    w_paddr_nxt    = r_paddr;
    w_pwdata_nxt   = r_pwdata;

    if (bus.ap_abort && (r_state != S_IDLE)) begin
      // Abandon the APB transfer and hand control back to the DP
      w_state_nxt   = S_IDLE;
      w_psel_nxt    = 1'b0;
      w_penable_nxt = 1'b0;
      w_ap_rdy_nxt  = 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            if (w_bus_addr) begin
              w_paddr_nxt   = (bus.ap_addr == A_DRW) ? {r_tar[31:2], 2'b00}
                                                     : {r_tar[31:4], bus.ap_addr[1:0], 2'b00};
              w_pwrite_nxt  = bus.ap_wen;
              w_pwdata_nxt  = bus.ap_wdata;
              w_is_drw_nxt  = (bus.ap_addr == A_DRW);
              w_psel_nxt    = 1'b1;
              w_penable_nxt = 1'b0;
              w_ap_rdy_nxt  = 1'b0;
              w_state_nxt   = S_SETUP;
            end else if (bus.ap_wen) begin
              if (bus.ap_addr == A_CSW) w_addrinc_nxt = bus.ap_wdata[5:4];
              if (bus.ap_addr == A_TAR) w_tar_nxt     = bus.ap_wdata;
            end else begin
              w_ap_rdata_nxt = w_reg_rdata;
            end
          end else if (w_strobe && !w_sel_hit && bus.ap_ren && !bus.ap_wen) begin
            w_ap_rdata_nxt = '0;
          end
        end
        S_SETUP: begin
          w_penable_nxt = 1'b1;
          w_state_nxt   = S_ACCESS;
        end
        S_ACCESS: begin
          if (bus.pready) begin
            w_psel_nxt    = 1'b0;
            w_penable_nxt = 1'b0;
            w_ap_rdy_nxt  = 1'b1;
            w_ap_err_nxt  = bus.pslverr;
            w_state_nxt   = S_IDLE;
            if (!r_pwrite) w_ap_rdata_nxt = bus.prdata;
            if (r_is_drw && (r_addrinc == 2'b01) && !bus.pslverr)
              w_tar_nxt = {r_tar[31:10], w_tar_inc, r_tar[1:0]};
          end
        end
        default: begin
          w_state_nxt   = S_IDLE;
          w_psel_nxt    = 1'b0;
          w_penable_nxt = 1'b0;
          w_ap_rdy_nxt  = 1'b1;
        end
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_tar      <= '0;
      r_addrinc  <= 2'b00;
      r_is_drw   <= 1'b0;
      r_ap_rdata <= '0;
      r_ap_rdy   <= 1'b1;
      r_ap_err   <= 1'b0;
      r_psel     <= 1'b0;
      r_penable  <= 1'b0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tar      <= w_tar_nxt;
      r_addrinc  <= w_addrinc_nxt;
      r_is_drw   <= w_is_drw_nxt;
      r_ap_rdata <= w_ap_rdata_nxt;
      r_ap_rdy   <= w_ap_rdy_nxt;
      r_ap_err   <= w_ap_err_nxt;
      r_psel     <= w_psel_nxt;
      r_penable  <= w_penable_nxt;
      r_pwrite   <= w_pwrite_nxt;
      r_paddr    <= w_paddr_nxt;
      r_pwdata   <= w_pwdata_nxt;
    end
  end

  assign bus.ap_rdata = r_ap_rdata;
  assign bus.ap_rdy   = r_ap_rdy;
  assign bus.ap_err   = r_ap_err;
  assign bus.psel     = r_psel;
  assign bus.penable  = r_penable;
  assign bus.pwrite   = r_pwrite;
  assign bus.paddr    = r_paddr;
  assign bus.pwdata   = r_pwdata;

endmodule
